// File: rtl/ysyx_25040129_mdu.sv
`default_nettype none
// ==== ysyx_25040129_mdu : iterative RV32M multiply/divide unit, one bit per cycle (rev 1.0) ====
module ysyx_25040129_mdu #(
  parameter int REGS_DIG = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          op,
  input  logic [31:0]         src1,
  input  logic [31:0]         src2,
  input  logic [REGS_DIG-1:0] rd_in,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         result,
  output logic [REGS_DIG-1:0] rd_out,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [63:0]         acc_q, acc_d;
  logic [31:0]         b_q, b_d;
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d;
  logic [31:0]         result_q, result_d;
  logic [REGS_DIG-1:0] rd_q, rd_d;

  // Operand conditioning: both datapaths work on magnitudes, sign is fixed up at the end
  logic        w_accept, w_s1_signed, w_s2_signed, w_neg1, w_neg2, w_neg;
  logic [31:0] w_mag1, w_mag2;
  logic        w_div_zero, w_ovf;
  logic [31:0] w_special_res;

  assign w_accept    = in_valid && in_ready;
  assign w_s1_signed = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
  assign w_s2_signed = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
  assign w_neg1      = w_s1_signed && src1[31];
  assign w_neg2      = w_s2_signed && src2[31];
  assign w_mag1      = w_neg1 ? (~src1 + 32'd1) : src1;
  assign w_mag2      = w_neg2 ? (~src2 + 32'd1) : src2;
  assign w_neg       = (op == 3'd6) ? w_neg1 : (w_neg1 ^ w_neg2);

  assign w_div_zero    = op[2] && (src2 == 32'd0);
  assign w_ovf         = ((op == 3'd4) || (op == 3'd6)) &&
                         (src1 == 32'h8000_0000) && (src2 == 32'hFFFF_FFFF);
  assign w_special_res = w_div_zero ? (op[1] ? src1 : 32'hFFFF_FFFF)
                                    : (op[1] ? 32'd0 : 32'h8000_0000);

  // acc = {partial product high, multiplier} or {partial remainder, dividend/quotient}
  logic [32:0] w_madd, w_cand, w_sub;
  logic        w_qbit, w_unused_bits;
  logic [31:0] w_rem;
  logic [63:0] w_mul_step, w_div_step, w_step, w_prod;
  logic [31:0] w_div_sel, w_div_res, w_mul_res;

  assign w_madd     = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
  assign w_mul_step = {w_madd, acc_q[31:1]};

  assign w_cand     = acc_q[63:31];
  assign w_qbit     = (w_cand >= {1'b0, b_q});
  assign w_sub      = w_cand - {1'b0, b_q};
  assign w_rem      = w_qbit ? w_sub[31:0] : w_cand[31:0];
  assign w_div_step = {w_rem, acc_q[30:0], w_qbit};
  assign w_unused_bits = w_sub[32] ^ w_cand[32];

  assign w_step    = op_q[2] ? w_div_step : w_mul_step;
  assign w_prod    = neg_q ? (~w_step + 64'd1) : w_step;
  assign w_mul_res = (op_q[1:0] == 2'd0) ? w_prod[31:0] : w_prod[63:32];
  assign w_div_sel = op_q[1] ? w_step[63:32] : w_step[31:0];
  assign w_div_res = neg_q ? (~w_div_sel + 32'd1) : w_div_sel;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    b_d      = b_q;
    op_d     = op_q;
    neg_d    = neg_q;
    result_d = result_q;
    rd_d     = rd_q;
    case (state_q)
      IDLE: begin
        if (w_accept) begin
          op_d  = op;
          rd_d  = rd_in;
          cnt_d = 5'd0;
          acc_d = {32'd0, w_mag1};
          b_d   = w_mag2;
          neg_d = w_neg;
          if (w_div_zero || w_ovf) begin
            result_d = w_special_res;
            state_d  = DONE;
          end else begin
            state_d  = BUSY;
          end
        end
      end
      BUSY: begin
        acc_d = w_step;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          result_d = op_q[2] ? w_div_res : w_mul_res;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      acc_q    <= 64'd0;
      b_q      <= 32'd0;
      op_q     <= 3'd0;
      neg_q    <= 1'b0;
      result_q <= 32'd0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      rd_q     <= rd_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !flush;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;
  assign rd_out    = rd_q;

endmodule
`default_nettype wire
